// File: rtl/char_console_if.sv
// char_console_if: byte stream, RAM write/read port and cursor status of the console writer.
interface char_console_if;
  logic       display_on;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic [4:0] cursor_row;
  logic [4:0] cursor_col;
  logic       busy;
  modport master (
    output display_on, in_data, in_valid, ram_dout,
    input  in_ready, ram_addr, ram_din, ram_we, cursor_row, cursor_col, busy
  );
  modport slave (
    input  display_on, in_data, in_valid, ram_dout,
    output in_ready, ram_addr, ram_din, ram_we, cursor_row, cursor_col, busy
  );
endinterface

// File: rtl/char_console_writer.sv
// char_console_writer: writes a byte stream into the 32x32 character RAM during blanking only.
// Define CONSOLE_SCROLL_EN to scroll the screen up at the last row instead of wrapping to row 0.
module char_console_writer #(
  parameter logic [7:0] FILL    = 8'h00,
  parameter logic [7:0] CR_CODE = 8'h0D,
  parameter logic [7:0] LF_CODE = 8'h0A,
  parameter logic [7:0] FF_CODE = 8'h0C,
  parameter logic [7:0] BS_CODE = 8'h08
) (
  input logic          clk,
  input logic          reset,
  char_console_if.slave io
);
  typedef enum logic [2:0] {
    IDLE, PUT, CLEAR, LINECLR
`ifdef CONSOLE_SCROLL_EN
    , SCR_RD, SCR_WR
`endif
  } state_t;
  state_t     r_state;
  logic [4:0] r_row, r_col;
  logic [7:0] r_byte;
  logic [9:0] r_cnt;
  logic       w_go, w_acc, w_we, w_last;
  logic [9:0] w_addr;
  logic [7:0] w_din;
  logic [4:0] w_nl_row;
  logic [9:0] w_nl_cnt;
  state_t     w_nl_state;
`ifdef CONSOLE_SCROLL_EN
  logic [7:0] r_data;
  logic       r_fresh;
`else
  logic       w_unused;
  assign w_unused = ^io.ram_dout;
`endif
  assign w_go   = !io.display_on;
  assign w_acc  = io.in_valid && io.in_ready;
  assign w_last = r_row == 5'd31;
  // Newline target: next row, or last-row wrap / scroll depending on build.
`ifdef CONSOLE_SCROLL_EN
  assign w_nl_row   = w_last ? r_row : r_row + 5'd1;
  assign w_nl_cnt   = w_last ? 10'd32 : 10'd0;
  assign w_nl_state = w_last ? SCR_RD : LINECLR;
`else
  assign w_nl_row   = r_row + 5'd1;
  assign w_nl_cnt   = 10'd0;
  assign w_nl_state = LINECLR;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_row   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
      r_byte  <= FILL;
`ifdef CONSOLE_SCROLL_EN
      r_data  <= FILL;
      r_fresh <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_byte <= io.in_data;
          if (io.in_data == CR_CODE) r_col <= '0;
          else if (io.in_data == LF_CODE) begin
            r_col   <= '0;
            r_row   <= w_nl_row;
            r_cnt   <= w_nl_cnt;
            r_state <= w_nl_state;
          end else if (io.in_data == BS_CODE) r_col <= (r_col != 5'd0) ? r_col - 5'd1 : r_col;
          else if (io.in_data == FF_CODE) begin
            r_row   <= '0;
            r_col   <= '0;
            r_cnt   <= '0;
            r_state <= CLEAR;
          end else r_state <= PUT;
        end
        PUT: if (w_go) begin
          r_col <= r_col + 5'd1;
          if (r_col == 5'd31) begin
            r_row   <= w_nl_row;
            r_cnt   <= w_nl_cnt;
            r_state <= w_nl_state;
          end else r_state <= IDLE;
        end
        CLEAR: if (w_go) begin
          r_cnt <= r_cnt + 10'd1;
          if (r_cnt == 10'h3FF) r_state <= IDLE;
        end
        LINECLR: if (w_go) begin
          r_cnt <= r_cnt + 10'd1;
          if (r_cnt[4:0] == 5'd31) r_state <= IDLE;
        end
`ifdef CONSOLE_SCROLL_EN
        SCR_RD: if (w_go) begin
          r_state <= SCR_WR;
          r_fresh <= 1'b1;
        end
        // Read data is live only in the first SCR_WR cycle; hold it across a deferred write.
        SCR_WR: begin
          r_fresh <= 1'b0;
          if (r_fresh) r_data <= io.ram_dout;
          if (w_go) begin
            r_cnt   <= r_cnt + 10'd1;
            r_state <= (r_cnt == 10'h3FF) ? LINECLR : SCR_RD;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
  always_comb begin
    w_we   = 1'b0;
    w_addr = {r_row, r_col};
    w_din  = FILL;
    case (r_state)
      PUT: begin
        w_we  = 1'b1;
        w_din = r_byte;
      end
      CLEAR: begin
        w_we   = 1'b1;
        w_addr = r_cnt;
      end
      LINECLR: begin
        w_we   = 1'b1;
        w_addr = {r_row, r_cnt[4:0]};
      end
`ifdef CONSOLE_SCROLL_EN
      SCR_RD: w_addr = r_cnt;
      SCR_WR: begin
        w_we   = 1'b1;
        w_addr = r_cnt - 10'd32;
        w_din  = r_fresh ? io.ram_dout : r_data;
      end
`endif
      default: w_we = 1'b0;
    endcase
  end
  assign io.ram_we     = w_we && w_go && !reset;
  assign io.ram_addr   = reset ? '0 : w_addr;
  assign io.ram_din    = reset ? FILL : w_din;
  assign io.in_ready   = (r_state == IDLE) && !reset;
  assign io.busy       = reset || (r_state != IDLE);
  assign io.cursor_row = r_row;
  assign io.cursor_col = r_col;
endmodule

// File: tb/tb_char_console_writer.sv
// tb_char_console_writer: directed checks of the console writer against a bench-owned RAM model.
module tb_char_console_writer;
  logic clk, reset;
  logic disp_manual, disp_rnd, tog, preload;
  logic [7:0] r_dout;
  logic [7:0] mem [0:1023];
  logic [9:0] wr_a [$];
  logic [7:0] wr_d [$];
  int cyc, viol, n_chk, n_err, base, t_acc, t_acc_prev;
  char_console_if io ();
  char_console_writer dut (.clk(clk), .reset(reset), .io(io));
  assign io.display_on = tog ? disp_rnd : disp_manual;
  assign io.ram_dout   = r_dout;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    r_dout <= mem[io.ram_addr];
    if (io.ram_we === 1'b1) begin
      mem[io.ram_addr] <= io.ram_din;
      wr_a.push_back(io.ram_addr);
      wr_d.push_back(io.ram_din);
      if (io.display_on) viol++;
    end
    if (preload) begin
      for (int i = 32; i < 64; i++) mem[i] <= 8'h09;
      mem[997] <= 8'h55;
    end
  end
  always @(negedge clk) disp_rnd = ($urandom_range(0, 1) == 1);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    io.in_valid = 1'b1;
    io.in_data  = b;
    while (!io.in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", n < 5000, 1);
    @(negedge clk);
    t_acc_prev = t_acc;
    t_acc = cyc;
  endtask
  task automatic put1(input logic [7:0] b);
    send(b);
    io.in_valid = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while (io.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < budget, 1);
  endtask
  function automatic int nwr();
    return wr_a.size() - base;
  endfunction
  function automatic logic [31:0] wa(input int k);
    return (base + k < wr_a.size()) ? {22'd0, wr_a[base + k]} : 32'hDEAD;
  endfunction
  function automatic logic [31:0] wd(input int k);
    return (base + k < wr_d.size()) ? {24'd0, wr_d[base + k]} : 32'hDEAD;
  endfunction
  function automatic logic clear_ok();
    if (nwr() != 1024) return 1'b0;
    for (int i = 0; i < 1024; i++)
      if (wa(i) != i || wd(i) != 0) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic row_is(input int r, input logic [7:0] v);
    for (int i = 0; i < 32; i++)
      if (mem[r * 32 + i] !== v) return 1'b0;
    return 1'b1;
  endfunction
  initial begin
    logic bad;
    n_chk = 0; n_err = 0; viol = 0; cyc = 0; t_acc = 0; t_acc_prev = 0;
    reset = 1'b1; disp_manual = 1'b0; tog = 1'b0; preload = 1'b0;
    io.in_valid = 1'b0; io.in_data = 8'h00;
    @(negedge clk);
    check("rst_we", io.ram_we, 0);
    check("rst_addr", io.ram_addr, 0);
    check("rst_din", io.ram_din, 0);
    check("rst_ready", io.in_ready, 0);
    check("rst_busy", io.busy, 1);
    check("rst_cursor", {io.cursor_row, io.cursor_col}, 0);
    base = wr_a.size();
    reset = 1'b0;
    wait_idle(1100);
    check("clear_seq", clear_ok(), 1);
    check("clear_ready", io.in_ready, 1);
    check("clear_cursor", {io.cursor_row, io.cursor_col}, 0);
    base = wr_a.size();
    send(8'h05);
    send(8'h07);
    io.in_valid = 1'b0;
    check("spacing_ge2", (t_acc - t_acc_prev) >= 2, 1);
    wait_idle(20);
    check("put_count", nwr(), 2);
    check("put0", {wa(0), wd(0)}, {32'd0, 32'h05});
    check("put1", {wa(1), wd(1)}, {32'd1, 32'h07});
    check("put_col", io.cursor_col, 2);
    base = wr_a.size();
    disp_manual = 1'b1;
    put1(8'h03);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (io.ram_we || !io.busy || io.in_ready) bad = 1'b1;
    end
    check("gated_hold", bad, 0);
    disp_manual = 1'b0;
    wait_idle(20);
    check("gated_count", nwr(), 1);
    check("gated_write", {wa(0), wd(0)}, {32'd2, 32'h03});
    put1(8'h0C);
    base = wr_a.size();
    wait_idle(1100);
    check("ff_clear", clear_ok(), 1);
    check("ff_cursor", {io.cursor_row, io.cursor_col}, 0);
    base = wr_a.size();
    for (int i = 0; i < 32; i++) send(8'h20 + 8'(i));
    io.in_valid = 1'b0;
    wait_idle(100);
    check("row_count", nwr(), 64);
    check("row_last", {wa(31), wd(31)}, {32'd31, 32'h3F});
    check("row_clr_first", {wa(32), wd(32)}, {32'd32, 32'h00});
    check("row_clr_last", {wa(63), wd(63)}, {32'd63, 32'h00});
    check("row_cursor", {io.cursor_row, io.cursor_col}, {5'd1, 5'd0});
    for (int i = 0; i < 3; i++) begin
      put1(8'h0A);
      wait_idle(100);
    end
    for (int i = 0; i < 10; i++) send(8'h20);
    io.in_valid = 1'b0;
    wait_idle(20);
    check("pos_4_10", {io.cursor_row, io.cursor_col}, {5'd4, 5'd10});
    base = wr_a.size();
    put1(8'h41);
    wait_idle(20);
    check("a_cursor", {io.cursor_row, io.cursor_col}, {5'd4, 5'd11});
    put1(8'h08);
    wait_idle(20);
    check("bs_cursor", {io.cursor_row, io.cursor_col}, {5'd4, 5'd10});
    put1(8'h0D);
    wait_idle(20);
    check("cr_cursor", {io.cursor_row, io.cursor_col}, {5'd4, 5'd0});
    check("a_count", nwr(), 1);
    check("a_write", {wa(0), wd(0)}, {32'd138, 32'h41});
    tog = 1'b1;
    for (int i = 0; i < 27; i++) begin
      put1(8'h0A);
      wait_idle(500);
    end
    check("at_row31", {io.cursor_row, io.cursor_col}, {5'd31, 5'd0});
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    base = wr_a.size();
    put1(8'h0A);
    wait_idle(10000);
`ifdef CONSOLE_SCROLL_EN
    check("scr_count", nwr(), 1024);
    check("scr_row0", row_is(0, 8'h09), 1);
    check("scr_row30", mem[965], 8'h55);
    check("scr_row31", row_is(31, 8'h00), 1);
    check("scr_cursor", {io.cursor_row, io.cursor_col}, {5'd31, 5'd0});
`else
    check("wrap_count", nwr(), 32);
    check("wrap_row0", row_is(0, 8'h00), 1);
    check("wrap_row1", row_is(1, 8'h09), 1);
    check("wrap_row31", mem[997], 8'h55);
    check("wrap_cursor", {io.cursor_row, io.cursor_col}, 0);
`endif
    put1(8'h0C);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_we", io.ram_we, 0);
    check("mid_rst_busy", io.busy, 1);
    base = wr_a.size();
    reset = 1'b0;
    wait_idle(10000);
    check("mid_rst_clear", clear_ok(), 1);
    check("mid_rst_cursor", {io.cursor_row, io.cursor_col}, 0);
    check("gating_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
